bin18_to_bcd_seg: RTL and testbench
===================================

Name: bin18_to_bcd_seg

Overview:
- Downstream display stage for the 18-bit accumulator output `bin_18`.
- Converts the unsigned binary value to 6 BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Drives six active-low seven-segment displays (HEX0..HEX5).
- Converts automatically whenever the input differs from the last converted value; no start strobe.

Parameters:
- WIDTH, 18: binary input width; also the number of shift cycles per conversion.
- DIGITS, 6: BCD digit count. Fixed at 6 for the hex port list; 10^DIGITS must exceed 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bin_in  input  WIDTH  unsigned binary value (accumulator `bin_18`).
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in [3:0].
- hex0..hex5  output  7 each  active-low segments, bit0=a .. bit6=g; hex0 = ones digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new outputs are published.

Behaviour:
- Everything is sampled on the rising edge of clk. rst is synchronous and active-high.
- Reset has priority over all other logic. On reset:
  - state=IDLE, last value=0, shift/BCD working registers=0, counter=0.
  - bcd_out=0, busy=0, done=0.
  - hex0..hex5=7'b1000000 ("0"); with the macro, hex1..hex5=7'h7F.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If bin_in != last: capture bin_in into the shift register and into last, clear the BCD working register, set counter=0, go to SHIFT, busy=1.
  - Otherwise hold and keep busy=0.
- SHIFT, one edge per bit:
  - Each working nibble >=5 gets +3 (combinationally).
  - Then shift {bcd_work, bin_shift} left by 1; counter++.
  - On the edge where counter==WIDTH-1, go to DONE.
  - WIDTH edges are spent in SHIFT in total.
- DONE, one edge:
  - Register bcd_out=bcd_work and all hex outputs.
  - done=1 for exactly the following cycle; busy=0; go to IDLE.
- Latency:
  - Outputs update on edge WIDTH+1 after the capture edge (19 edges at default).
  - done is high during the cycle after that edge.
  - Minimum spacing between conversions: WIDTH+2 cycles.
- Input change during SHIFT/DONE:
  - Ignored by the running conversion, which completes with the captured value.
  - On return to IDLE the mismatch is detected and a new conversion starts on the next edge.
  - No conversion is lost or truncated.
- Stable input: no conversions, done stays low, outputs hold.
- Input equal to 0 after reset: no conversion is needed; reset outputs are already correct.
- Range: 262143 (max 18-bit) -> 24'h262143. No overflow is possible at the defaults.
- Segment decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 is unreachable; decode it as blank 7'h7F.
- Reset mid-conversion: abort immediately, apply reset values, no done pulse.
- Outputs are registered only. No combinational path from bin_in to any output.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In DONE, each hex digit above the most-significant nonzero digit is driven 7'h7F (blank).
  - hex0 is always displayed, so value 0 shows a single "0".
  - bcd_out is unaffected.
- Undefined: all six digits always displayed, including leading zeros.

Test Plan:
- Reset, then hold bin_in=0 for 50 cycles:
  - bcd_out=0, hex0..5=7'b1000000 (macro off), busy=0.
  - done never pulses.
- From idle, bin_in=123456:
  - busy rises the cycle after capture.
  - On edge 19 after capture, bcd_out=24'h123456; hex5=1111001, hex0=0000010.
  - done high exactly 1 cycle; busy low.
- bin_in=262143 (max):
  - bcd_out=24'h262143.
  - Then bin_in=0 gives bcd_out=0 after a further 19 edges.
- bin_in=100; at edge 5 after capture change to 999:
  - First done with bcd_out=24'h000100.
  - Second conversion starts on the edge after return to IDLE.
  - Second done with 24'h000999. Exactly two done pulses.
- bin_in=54321; assert rst at edge 10 of SHIFT:
  - Reset outputs on the next cycle, no done.
  - After rst is released, with bin_in still 54321, a full conversion yields 24'h054321.
- With LEADING_ZERO_BLANK_EN, bin_in=42:
  - hex5..hex2=7'h7F, hex1=0011001, hex0=0100100, bcd_out=24'h000042.
  - bin_in=0 gives hex0=1000000 and the rest 7'h7F.

Source files
------------

// File: rtl/bin18_to_bcd_seg.sv
// -----------------------------------------------------------------------------
// bin18_to_bcd_seg
//
// Display stage for the 18-bit accumulator value. Whenever bin_in differs from
// the last converted value, an iterative shift-add-3 (double-dabble) engine
// converts it to packed BCD, one input bit per clock, and then publishes the
// BCD word and six active-low seven-segment patterns in a single edge.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, hex digits above the most-significant nonzero digit are
//   blanked (7'h7F); hex0 always shows a digit. bcd_out is unaffected.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   bin_in     unsigned binary input value (WIDTH bits)
//   bcd_out    packed BCD, ones digit in [3:0] (4*DIGITS bits)
//   hex0..hex5 active-low segments, bit0=a .. bit6=g; hex0 = ones digit
//   busy       high while a conversion is in progress
//   done       one-cycle pulse after new outputs are published
// -----------------------------------------------------------------------------
module bin18_to_bcd_seg #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW        = $clog2(WIDTH + 1);
  localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [DIGITS-1:0][6:0] hex_t;

  // Active-low decode; codes above 9 cannot occur but decode to blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Pre-shift correction: every BCD nibble of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decade.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    r = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic hex_t decode_all(input logic [4*DIGITS-1:0] b);
    hex_t        h;
    int unsigned idx;
    logic        seen_nz;
    h       = '1;
    seen_nz = 1'b0;
    // Walk from the most-significant digit down so leading zeros are known.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx = DIGITS - 1 - k;
      if (b[4*idx +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (!seen_nz && idx != 0) begin
        h[idx] = SEG_BLANK;
      end else begin
        h[idx] = seg7(b[4*idx +: 4]);
      end
`else
      h[idx] = seg7(b[4*idx +: 4]);
`endif
    end
    return h;
  endfunction

  function automatic hex_t reset_hex();
    hex_t h;
    for (int unsigned i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      h[i] = (i == 0) ? SEG_ZERO : SEG_BLANK;
`else
      h[i] = SEG_ZERO;
`endif
    end
    return h;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     last_q, last_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [4*DIGITS-1:0]  work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  hex_t                 hex_q, hex_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4*DIGITS-1:0]  work_adj;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      hex_q   <= reset_hex();
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    shift_d  = shift_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    hex_d    = hex_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    work_adj = add3(work_q);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bin_in != last_q) begin
          shift_d = bin_in;
          last_d  = bin_in;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // {work, shift} as one register shifted left after the +3 correction.
        work_d  = {work_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = work_q;
        hex_d   = decode_all(work_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bcd_out = bcd_q;
  assign hex0    = hex_q[0];
  assign hex1    = hex_q[1];
  assign hex2    = hex_q[2];
  assign hex3    = hex_q[3];
  assign hex4    = hex_q[4];
  assign hex5    = hex_q[5];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bin18_to_bcd_seg.sv
module tb_bin18_to_bcd_seg;

  logic        clk;
  logic        rst;
  logic [17:0] bin_in;
  logic [23:0] bcd_out;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;
  logic        done;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [6:0] seg_tab [10];

  typedef struct {
    int unsigned value;
    logic [23:0] exp_bcd;
  } vec_t;

  vec_t vecs [10];

  bin18_to_bcd_seg #(.WIDTH(18), .DIGITS(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, segment pattern by table lookup.
  function automatic int unsigned digit_of(input int unsigned v, input int unsigned i);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [23:0] model_bcd(input int unsigned v);
    logic [23:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic logic [6:0] model_hex(input int unsigned v, input int unsigned i);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < i; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && v < p) return 7'h7F;
`endif
    return seg_tab[digit_of(v, i)];
  endfunction

  task automatic check_display(input string tag, input int unsigned v);
    logic [6:0] h [6];
    h[0] = hex0; h[1] = hex1; h[2] = hex2; h[3] = hex3; h[4] = hex4; h[5] = hex5;
    check($sformatf("%s bcd_out", tag), 32'(bcd_out), 32'(model_bcd(v)));
    for (int i = 0; i < 6; i++)
      check($sformatf("%s hex%0d", tag, i), 32'(h[i]), 32'(model_hex(v, i)));
  endtask

  // Waits (bounded) for done; n counts edges consumed, busy1 is busy after the first.
  task automatic wait_done(output int unsigned n, output bit seen, output logic busy1);
    n = 0;
    seen = 1'b0;
    busy1 = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) busy1 = busy;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic convert(input string tag, input int unsigned v, input logic [23:0] exp_bcd);
    int unsigned n;
    bit          seen;
    logic        b1;
    bin_in = 18'(v);
    wait_done(n, seen, b1);
    check($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s latency", tag), n, 32'd20);
    check($sformatf("%s busy_after_capture", tag), 32'(b1), 32'd1);
    check($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
    check($sformatf("%s bcd_const", tag), 32'(bcd_out), 32'(exp_bcd));
    check_display(tag, v);
    @(posedge clk); #1;
    check($sformatf("%s done_width", tag), 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned n, dcount, bcount, prev, v;
    bit          seen;
    logic        b1;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{123456, 24'h123456};
    vecs[1] = '{262143, 24'h262143};
    vecs[2] = '{0,      24'h000000};
    vecs[3] = '{1,      24'h000001};
    vecs[4] = '{9,      24'h000009};
    vecs[5] = '{10,     24'h000010};
    vecs[6] = '{99999,  24'h099999};
    vecs[7] = '{100000, 24'h100000};
    vecs[8] = '{42,     24'h000042};
    vecs[9] = '{55555,  24'h055555};

    // Reset, then stable zero input: nothing should happen.
    rst = 1'b1;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_display("reset", 0);
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (busy) bcount++;
    end
    check("idle done_pulses", dcount, 32'd0);
    check("idle busy_cycles", bcount, 32'd0);
    check_display("idle", 0);

    // Directed table.
    for (int i = 0; i < 10; i++)
      convert($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_bcd);

    // Input change mid-conversion: both values converted, in order.
    bin_in = 18'd100;
    repeat (6) @(posedge clk);
    #1;
    bin_in = 18'd999;
    wait_done(n, seen, b1);
    check("chg first_seen", 32'(seen), 32'd1);
    check("chg first_bcd", 32'(bcd_out), 32'h000100);
    @(posedge clk); #1;
    check("chg done_width", 32'(done), 32'd0);
    wait_done(n, seen, b1);
    check("chg second_seen", 32'(seen), 32'd1);
    check("chg second_gap", n, 32'd19);
    check("chg second_bcd", 32'(bcd_out), 32'h000999);
    check_display("chg", 999);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("chg extra_pulses", dcount, 32'd0);

    // Reset in the middle of SHIFT: abort without done, then reconvert.
    bin_in = 18'd54321;
    @(posedge clk); #1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) dcount++;
    check("rstmid done_pulses", dcount, 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check_display("rstmid", 0);
    rst = 1'b0;
    wait_done(n, seen, b1);
    check("rstmid reconv_seen", 32'(seen), 32'd1);
    check("rstmid reconv_latency", n, 32'd20);
    check("rstmid reconv_bcd", 32'(bcd_out), 32'h054321);
    check_display("rstmid_reconv", 54321);
    @(posedge clk); #1;

    // Random values against the arithmetic reference model.
    prev = 54321;
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(262143, 0);
      if (v == prev) v = v ^ 1;
      bin_in = 18'(v);
      wait_done(n, seen, b1);
      check($sformatf("rnd%0d done_seen", i), 32'(seen), 32'd1);
      check_display($sformatf("rnd%0d", i), v);
      @(posedge clk); #1;
      prev = v;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
